// File: rtl/cpu_pkg.sv
// Shared types and constants for the scalar pipeline: opcode/cmd encodings,
// ALU operation enum, and the control bundle carried in the D->E register.
package cpu_pkg;

  localparam int          REG_AW  = 4;
  localparam logic [3:0]  PC_IDX  = 4'd15;
  localparam logic [3:0]  COND_AL = 4'hE;

  localparam logic [1:0]  OP_DP   = 2'b00;
  localparam logic [1:0]  OP_MEM  = 2'b01;
  localparam logic [1:0]  OP_BR   = 2'b10;

  localparam logic [3:0]  CMD_AND = 4'b0000;
  localparam logic [3:0]  CMD_SUB = 4'b0010;
  localparam logic [3:0]  CMD_ADD = 4'b0100;
  localparam logic [3:0]  CMD_ORR = 4'b1100;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic [1:0] flag_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // FlagWrite: NZ follows S; CV only for arithmetic ops.
  function automatic logic [1:0] flag_write_f(input logic s, input logic arith);
    return {s, s & arith};
  endfunction

endpackage

// File: rtl/regfile_3p.sv
// Scalar register file: two combinational read ports, one write port.
// The top index aliases PC+8; a same-cycle write is forwarded to readers.
module regfile_3p
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // R15 is never stored; its slot stays at zero and is shadowed by pc_i on read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != PC_IDX)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Port 1 read with PC alias and write-through.
  always_comb begin
    if (ra1_i == PC_IDX) begin
      rd1_o = pc_i;
    end else if (we_i && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = mem_q[ra1_i];
    end
  end

  // Port 2 read with PC alias and write-through.
  always_comb begin
    if (ra2_i == PC_IDX) begin
      rd2_o = pc_i;
    end else if (we_i && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the scalar instruction, reads the register file and
// loads the D->E pipeline register (with flush/stall from the hazard unit).
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       InstrD,
  input  logic [31:0]       InstrDV,
  input  logic [DATA_W-1:0] PCPlus8D,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteW,
  input  logic              FlushE,
  input  logic              StallE,
  output logic [REG_AW-1:0] RA1D,
  output logic [REG_AW-1:0] RA2D,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [REG_AW-1:0] WA3E,
  output logic [REG_AW-1:0] RA1E,
  output logic [REG_AW-1:0] RA2E,
  output logic [3:0]        CondE,
  output logic [1:0]        ALUControlE,
  output logic              ALUSrcE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              MemtoRegE,
  output logic              BranchE,
  output logic              PCSrcE,
  output logic [1:0]        FlagWriteE,
  output logic [31:0]       InstrVE
);

  logic [1:0]        op_s;
  logic [5:0]        funct_s;
  logic [3:0]        cmd_s;
  logic [3:0]        rn_s;
  logic [3:0]        rd_s;
  logic [3:0]        rm_s;
  logic              is_str_s;
  ctrl_t             ctrl_d;
  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] wa3_q;
  logic [REG_AW-1:0] ra1_q;
  logic [REG_AW-1:0] ra2_q;
  logic [3:0]        cond_q;
  logic [31:0]       instr_v_q;

  assign op_s    = InstrD[27:26];
  assign funct_s = InstrD[25:20];
  assign cmd_s   = funct_s[4:1];
  assign rn_s    = InstrD[19:16];
  assign rd_s    = InstrD[15:12];
  assign rm_s    = InstrD[3:0];

  // Main decoder: controls, immediate and source-index selection.
  always_comb begin
    ctrl_d   = CTRL_BUBBLE;
    imm_d    = '0;
    is_str_s = 1'b0;
    case (op_s)
      OP_DP: begin
        imm_d = {{(DATA_W-8){1'b0}}, InstrD[7:0]};
        ctrl_d.alu_src   = funct_s[5];
        ctrl_d.reg_write = 1'b1;
        case (cmd_s)
          CMD_ADD: begin
            ctrl_d.alu_ctrl   = ALU_ADD;
            ctrl_d.flag_write = flag_write_f(funct_s[0], 1'b1);
          end
          CMD_SUB: begin
            ctrl_d.alu_ctrl   = ALU_SUB;
            ctrl_d.flag_write = flag_write_f(funct_s[0], 1'b1);
          end
          CMD_AND: begin
            ctrl_d.alu_ctrl   = ALU_AND;
            ctrl_d.flag_write = flag_write_f(funct_s[0], 1'b0);
          end
          CMD_ORR: begin
            ctrl_d.alu_ctrl   = ALU_ORR;
            ctrl_d.flag_write = flag_write_f(funct_s[0], 1'b0);
          end
          default: ctrl_d = CTRL_BUBBLE;
        endcase
      end
      OP_MEM: begin
        imm_d = {{(DATA_W-12){1'b0}}, InstrD[11:0]};
        ctrl_d.alu_src  = 1'b1;
        ctrl_d.alu_ctrl = ALU_ADD;
        if (funct_s[0]) begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.mem_to_reg = 1'b1;
        end else begin
          ctrl_d.mem_write = 1'b1;
          is_str_s         = 1'b1;
        end
      end
      OP_BR: begin
        imm_d = {{(DATA_W-26){InstrD[23]}}, InstrD[23:0], 2'b00};
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_src  = 1'b1;
        ctrl_d.alu_ctrl = ALU_ADD;
      end
      default: ctrl_d = CTRL_BUBBLE;
    endcase
    ctrl_d.pc_src = ((rd_s == PC_IDX) && ctrl_d.reg_write) || ctrl_d.branch;
    RA1D = ctrl_d.branch ? PC_IDX : rn_s;
    RA2D = is_str_s ? rd_s : rm_s;
  end

  regfile_3p #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (RegWriteW),
    .wa_i    (WA3W),
    .wd_i    (ResultW),
    .ra1_i   (RA1D),
    .ra2_i   (RA2D),
    .pc_i    (PCPlus8D),
    .rd1_o   (rd1_s),
    .rd2_o   (rd2_s)
  );

  // D->E register: reset and flush load a bubble (cond AL), stall holds.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrl_q    <= CTRL_BUBBLE;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      wa3_q     <= '0;
      ra1_q     <= '0;
      ra2_q     <= '0;
      cond_q    <= COND_AL;
      instr_v_q <= '0;
    end else if (!StallE) begin
      ctrl_q    <= ctrl_d;
      rd1_q     <= rd1_s;
      rd2_q     <= rd2_s;
      imm_q     <= imm_d;
      wa3_q     <= rd_s;
      ra1_q     <= RA1D;
      ra2_q     <= RA2D;
      cond_q    <= InstrD[31:28];
      instr_v_q <= InstrDV;
    end
  end

  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ExtImmE     = imm_q;
  assign WA3E        = wa3_q;
  assign RA1E        = ra1_q;
  assign RA2E        = ra2_q;
  assign CondE       = cond_q;
  assign ALUControlE = ctrl_q.alu_ctrl;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign MemtoRegE   = ctrl_q.mem_to_reg;
  assign BranchE     = ctrl_q.branch;
  assign PCSrcE      = ctrl_q.pc_src;
  assign FlagWriteE  = ctrl_q.flag_write;
  assign InstrVE     = instr_v_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors for decode, register
// file bypass/reset behaviour and the flush/stall priority of the E register.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, InstrDV, PCPlus8D, ResultW;
  logic [3:0]  WA3W;
  logic        RegWriteW, FlushE, StallE;
  logic [3:0]  RA1D, RA2D, WA3E, RA1E, RA2E, CondE;
  logic [31:0] RD1E, RD2E, ExtImmE, InstrVE;
  logic [1:0]  ALUControlE, FlagWriteE;
  logic        ALUSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, PCSrcE;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .InstrDV(InstrDV), .PCPlus8D(PCPlus8D),
    .ResultW(ResultW), .WA3W(WA3W), .RegWriteW(RegWriteW), .FlushE(FlushE), .StallE(StallE),
    .RA1D(RA1D), .RA2D(RA2D), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E),
    .RA1E(RA1E), .RA2E(RA2E), .CondE(CondE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .BranchE(BranchE),
    .PCSrcE(PCSrcE), .FlagWriteE(FlagWriteE), .InstrVE(InstrVE)
  );

  // Packed view of all E controls: {ALUControl, ALUSrc, RegWrite, MemWrite, MemtoReg, Branch, PCSrc, FlagWrite}
  logic [9:0] ctrl_v;
  assign ctrl_v = {ALUControlE, ALUSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, PCSrcE, FlagWriteE};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; FlushE = 1'b0; StallE = 1'b0;
    InstrD = 32'hE0830003; InstrDV = 32'hAAAA5555; PCPlus8D = 32'd0;
    RegWriteW = 1'b1; WA3W = 4'd3; ResultW = 32'd55;
    tick();
    check("rst_ctrl", {22'd0, ctrl_v}, 32'd0);
    check("rst_cond", {28'd0, CondE}, 32'hE);
    check("rst_instrv", InstrVE, 32'd0);
    check("rst_rd1", RD1E, 32'd0);

    // Write dropped during reset: R3 still reads 0.
    reset = 1'b0; RegWriteW = 1'b0;
    tick();
    check("r3_rd1", RD1E, 32'd0);
    check("r3_rd2", RD2E, 32'd0);
    check("r3_regwrite", {31'd0, RegWriteE}, 32'd1);

    RegWriteW = 1'b1; WA3W = 4'd1; ResultW = 32'd5;
    tick();
    WA3W = 4'd2; ResultW = 32'd7;
    tick();
    RegWriteW = 1'b0; InstrD = 32'hE0810002; InstrDV = 32'h12345678;
    #1;
    check("add_ra1d", {28'd0, RA1D}, 32'd1);
    check("add_ra2d", {28'd0, RA2D}, 32'd2);
    tick();
    check("add_rd1", RD1E, 32'd5);
    check("add_rd2", RD2E, 32'd7);
    check("add_wa3", {28'd0, WA3E}, 32'd0);
    check("add_ra1e_ra2e", {24'd0, RA1E, RA2E}, 32'h12);
    check("add_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b00_0_1_0_0_0_0_00});
    check("add_cond", {28'd0, CondE}, 32'hE);
    check("add_instrv", InstrVE, 32'h12345678);

    // Same-cycle write-through.
    RegWriteW = 1'b1; WA3W = 4'd1; ResultW = 32'd9;
    tick();
    check("bypass_rd1", RD1E, 32'd9);
    check("bypass_rd2", RD2E, 32'd7);

    // SUBS R2,R1,R2
    RegWriteW = 1'b0; InstrD = 32'hE0512002;
    tick();
    check("subs_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b01_0_1_0_0_0_0_11});
    check("subs_rd1", RD1E, 32'd9);
    check("subs_wa3", {28'd0, WA3E}, 32'd2);

    // ORRS R0,R1,#0xFF
    InstrD = 32'hE39100FF;
    tick();
    check("orrs_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b11_1_1_0_0_0_0_10});
    check("orrs_imm", ExtImmE, 32'h000000FF);

    // EOR is unsupported -> bubble controls.
    InstrD = 32'hE0210002;
    tick();
    check("eor_bubble", {22'd0, ctrl_v}, 32'd0);

    // ADD R15,R1,R2 -> PCSrc
    InstrD = 32'hE081F002;
    tick();
    check("addpc_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b00_0_1_0_0_0_1_00});

    InstrD = 32'hEA000002; PCPlus8D = 32'd100;
    #1;
    check("b_ra1d", {28'd0, RA1D}, 32'd15);
    tick();
    check("b_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b00_1_0_0_0_1_1_00});
    check("b_rd1", RD1E, 32'd100);
    check("b_imm", ExtImmE, 32'd8);

    InstrD = 32'hEAFFFFFE;
    tick();
    check("bneg_imm", ExtImmE, 32'hFFFFFFF8);

    // STR R1,[R3,#4]
    InstrD = 32'hE5831004;
    #1;
    check("str_ra2d", {28'd0, RA2D}, 32'd1);
    tick();
    check("str_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b00_1_0_1_0_0_0_00});
    check("str_imm", ExtImmE, 32'd4);
    check("str_rd2", RD2E, 32'd9);

    // LDR R1,[R3,#4]
    InstrD = 32'hE5931004;
    #1;
    check("ldr_ra2d", {28'd0, RA2D}, 32'd4);
    tick();
    check("ldr_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b00_1_1_0_1_0_0_00});

    InstrD = 32'hEC000000;
    tick();
    check("op11_bubble", {22'd0, ctrl_v}, 32'd0);

    // Flush with ADD in D.
    InstrD = 32'hE0810002; FlushE = 1'b1;
    tick();
    check("flush_ctrl", {22'd0, ctrl_v}, 32'd0);
    check("flush_rd1", RD1E, 32'd0);
    check("flush_cond", {28'd0, CondE}, 32'hE);
    check("flush_instrv", InstrVE, 32'd0);

    FlushE = 1'b0;
    tick();
    check("reload_rd1", RD1E, 32'd9);

    // Stall holds E while W still writes R1=11.
    StallE = 1'b1; InstrD = 32'hEA000002; RegWriteW = 1'b1; WA3W = 4'd1; ResultW = 32'd11;
    tick();
    check("stall_rd1", RD1E, 32'd9);
    check("stall_ctrl", {22'd0, ctrl_v}, {22'd0, 10'b00_0_1_0_0_0_0_00});

    StallE = 1'b0; RegWriteW = 1'b0; InstrD = 32'h10810002;
    tick();
    check("post_stall_rd1", RD1E, 32'd11);
    check("post_stall_cond", {28'd0, CondE}, 32'h1);

    FlushE = 1'b1; StallE = 1'b1;
    tick();
    check("flush_stall_ctrl", {22'd0, ctrl_v}, 32'd0);
    check("flush_stall_rd1", RD1E, 32'd0);
    check("flush_stall_cond", {28'd0, CondE}, 32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
